// File: rtl/counter_cmd_seq.sv
// Command sequencer driving the load/direction/enable controls of a 16-bit up/down counter.
// Define CNT_SEQ_ABORT_EN to add the abort input and the aborted completion qualifier.
module counter_cmd_seq #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
`ifdef CNT_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | ready for a command; done pulses here after completion
  // LOAD  | one cycle with ld_cnt low, data_in = captured value
  // RUN   | count_enb high for the remaining step count
  // WAIT  | counter held for the step count (also the one-cycle gap for N=0)
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b11;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  data_d;
  logic              ld_d, updn_d, enb_d, busy_d, done_d;
  logic              accept, abort_hit;

  assign cmd_ready = rst_ && (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign steps     = cmd_arg[STEP_W-1:0];

`ifdef CNT_SEQ_ABORT_EN
  logic aborted_d;
  assign abort_hit = abort && ((state_q == S_RUN) || (state_q == S_WAIT));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      data_in   <= '0;
      ld_cnt    <= 1'b1;
      updn_cnt  <= 1'b0;
      count_enb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef CNT_SEQ_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      data_in   <= data_d;
      ld_cnt    <= ld_d;
      updn_cnt  <= updn_d;
      count_enb <= enb_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef CNT_SEQ_ABORT_EN
      aborted   <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            state_d = S_LOAD;
          end else if (steps == '0) begin
            // zero-step commands spend one idle-looking cycle so done lands one cycle after accept
            state_d = S_WAIT;
            rem_d   = STEP_W'(1);
          end else begin
            state_d = (cmd_op == OP_HOLD) ? S_WAIT : S_RUN;
            rem_d   = steps;
          end
        end
      end
      S_LOAD: state_d = S_IDLE;
      default: begin
        if (abort_hit || (rem_q <= STEP_W'(1))) begin
          state_d = S_IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
    endcase
  end

  // Outputs are computed one cycle ahead from the next state and then registered.
  always_comb begin
    data_d = data_in;
    updn_d = updn_cnt;
    ld_d   = 1'b1;
    enb_d  = (state_d == S_RUN);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
    if ((state_q == S_IDLE) && accept) begin
      if (cmd_op == OP_LOAD) begin
        ld_d   = 1'b0;
        data_d = cmd_arg;
      end
      if (state_d == S_RUN) updn_d = (cmd_op == OP_UP);
    end
  end

`ifdef CNT_SEQ_ABORT_EN
  assign aborted_d = abort_hit;
`endif

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer that sits directly upstream of the 16-bit up/down counter and drives its control inputs (`data_in`, `ld_cnt`, `updn_cnt`, `count_enb`). It accepts load, count-up, count-down and hold commands over a valid/ready handshake. Each command is expanded into a cycle-exact sequence of counter control signals. A one-cycle `done` pulse marks completion, so a host can script counter activity without cycle-level bookkeeping.

## Interface
- `WIDTH`, default 16: counter data width; sets the widths of `data_in` and `cmd_arg`.
- `STEP_W`, default 8: width of the step count; taken from `cmd_arg[STEP_W-1:0]`.

- `clk`  in  1  rising-edge clock.
- `rst_`  in  1  reset; one clock, reset is synchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  command: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_arg`  in  WIDTH  load value for LOAD; step count N in the low `STEP_W` bits otherwise.
- `data_in`  out  WIDTH  load value to the counter.
- `ld_cnt`  out  1  active-low counter load.
- `updn_cnt`  out  1  count direction: 1 = up, 0 = down.
- `count_enb`  out  1  counter enable, active high.
- `busy`  out  1  a command is executing.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`; present only with `CNT_SEQ_ABORT_EN`.
- `abort`  in  1  abort request; present only with `CNT_SEQ_ABORT_EN`.

## Operation
- FSM states: IDLE, LOAD, RUN, WAIT.
- **IDLE**
  - `cmd_ready`=1.
  - A handshake occurs on a rising edge with `cmd_valid` && `cmd_ready`; `cmd_op`/`cmd_arg` are captured on that edge.
- **LOAD**
  - Lasts 1 cycle: `ld_cnt`=0, `data_in`=captured arg, `count_enb`=0.
  - Then returns to IDLE with `done`=1.
- **UP/DOWN, N>0 → RUN** for exactly N cycles:
  - `count_enb`=1, `ld_cnt`=1.
  - `updn_cnt`=1 for UP, 0 for DOWN.
  - An internal remaining-count register loads N and decrements each RUN cycle; the state exits when it reaches 1.
- **HOLD, N>0 → WAIT** for N cycles with `count_enb`=0 and `ld_cnt`=1.
- **N=0** for UP/DOWN/HOLD: no control activity; returns to IDLE with `done`=1 on the next edge.
- `data_in` keeps its last loaded value outside LOAD.
- `updn_cnt` keeps its last value outside RUN.
- `busy`=1 in LOAD/RUN/WAIT, and also in the accept-to-first-action gap.
- `done` and `cmd_ready` are both high in the first IDLE cycle after completion, so back-to-back commands are accepted with zero bubble.
- All outputs are registered. `cmd_ready` is decoded from a registered state.
- Reset (`rst_`=0 at a rising edge), from any state including mid-RUN:
  - state=IDLE, `ld_cnt`=1, `count_enb`=0, `updn_cnt`=0, `data_in`=0.
  - `busy`=0, `done`=0, `aborted`=0, remaining count=0.
  - `cmd_ready`=0 while `rst_` is low.
  - No `done` pulse is emitted for a command killed by reset.

## Timing
- Accept on edge k. The first control cycle is k→k+1, so the counter acts on edge k+1.
- LOAD: `ld_cnt` low for exactly one cycle; `done` high in cycle k+1→k+2.
- UP/DOWN N: `count_enb` high for N consecutive cycles starting at edge k; `done` is high in the cycle after the last enabled cycle.
- Total latency from accept edge to `done` assertion: 1 cycle for LOAD; N cycles for UP/DOWN/HOLD with N>0; 1 cycle for N=0.
- `cmd_valid` held while `cmd_ready`=0 has no effect.
- Inputs are not required to be stable outside the handshake edge.
- Counter wrap (e.g., 0xFFFF+1) is the counter's concern; the sequencer does not inspect counter output.

## Configuration
- `CNT_SEQ_ABORT_EN` defined:
  - Adds the `abort` input and the `aborted` output.
  - `abort`=1 at an edge while in RUN or WAIT forces IDLE on that edge: `count_enb`=0 from that edge onward, then `done`=1 and `aborted`=1 for one cycle.
  - `abort` is ignored in IDLE and LOAD.
  - On normal completion, `aborted`=0.
- `CNT_SEQ_ABORT_EN` undefined: neither port exists, and every command always runs to completion.

## Test plan
- Reset then LOAD 0x1234:
  - `ld_cnt`=0 for exactly 1 cycle with `data_in`=0x1234.
  - `done` pulses one cycle later.
  - Counter reads 0x1234.
- LOAD 0xFFFE, then UP N=3 back-to-back:
  - `count_enb` high for 3 cycles with `updn_cnt`=1.
  - Counter reads 0x0001 (wrap).
  - No idle cycle between commands.
- DOWN N=5 from 0x0003: 5 enabled cycles with `updn_cnt`=0; counter reads 0xFFFE; `done` exactly once.
- HOLD N=4 then UP N=0:
  - `count_enb`=0 for 4 cycles with counter stable.
  - The UP N=0 produces `done` one cycle after accept with no enable.
- `rst_` low on the 3rd cycle of UP N=10:
  - `count_enb`=0 and `cmd_ready`=0 during reset.
  - No `done` pulse; `cmd_ready`=1 in the first cycle after `rst_` returns high.
- With `CNT_SEQ_ABORT_EN`: UP N=200 with `abort` asserted after 7 enabled cycles → exactly 7 increments; `done`=1 and `aborted`=1 for one cycle.
